// File: rtl/capture_buffer.sv
// Oscilloscope capture buffer: decimates ADC samples, arms on a level trigger or auto
// timeout, records 256 samples, and commits them to the display on the next vblank rise.
module capture_buffer #(
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] adc_data,
   input  logic        adc_valid,
   input  logic [3:0]  decimation,
   input  logic [11:0] trigger_level,
   input  logic        trigger_edge,
   input  logic        hold,
   input  logic        vblnk,
   output logic [11:0] data_display [0:255],
   output logic        frame_ready,
   output logic        trig_auto,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_WAIT_TRIG = 2'b01,
      S_CAPTURE   = 2'b10,
      S_DONE      = 2'b11
   } state_t;

   localparam int              TO_W    = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [3:0]      r_dec_cnt;
   logic [11:0]     r_prev_sample;
   logic            r_prev_valid;
   logic [TO_W-1:0] r_to_cnt;
   logic [7:0]      r_wr_ptr;
   logic            r_auto_flag;
   logic            r_vblnk_d;
   logic            r_frame_ready;
   logic            r_trig_auto;
   logic [11:0]     r_cap     [0:255];
   logic [11:0]     r_display [0:255];

   logic w_accept;
   logic w_rise_hit;
   logic w_fall_hit;
   logic w_trig;
   logic w_timeout;
   logic w_vblnk_rise;
   logic w_commit;
   logic w_cap_write;
   logic w_start_cap;
   logic w_state_change;

   // A decimation value lowered below the running count releases the very next valid sample.
   assign w_accept     = adc_valid && (r_dec_cnt >= decimation);
   assign w_rise_hit   = (r_prev_sample < trigger_level) && (adc_data >= trigger_level);
   assign w_fall_hit   = (r_prev_sample > trigger_level) && (adc_data <= trigger_level);
   assign w_trig       = (r_state == S_WAIT_TRIG) && w_accept && r_prev_valid &&
                         (trigger_edge ? w_fall_hit : w_rise_hit);
   assign w_timeout    = (r_state == S_WAIT_TRIG) && w_accept && (r_to_cnt == TO_LAST);
   assign w_vblnk_rise = vblnk & ~r_vblnk_d;
   assign w_commit     = (r_state == S_DONE) && w_vblnk_rise;
   assign w_cap_write  = (r_state == S_CAPTURE) && w_accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (!hold) w_next_state = S_WAIT_TRIG;
         end
         S_WAIT_TRIG: begin
            if (hold)                      w_next_state = S_IDLE;
            else if (w_trig || w_timeout)  w_next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (w_cap_write && (r_wr_ptr == 8'hFF)) w_next_state = S_DONE;
         end
         S_DONE: begin
            if (w_commit) w_next_state = hold ? S_IDLE : S_WAIT_TRIG;
         end
      endcase
   end

   assign w_state_change = (w_next_state != r_state);
   assign w_start_cap    = (r_state == S_WAIT_TRIG) && (w_next_state == S_CAPTURE);

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dec_cnt <= '0;
      end else if (w_state_change) begin
         r_dec_cnt <= '0;
      end else if (adc_valid) begin
         r_dec_cnt <= w_accept ? 4'd0 : r_dec_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_sample <= '0;
         r_prev_valid  <= 1'b0;
         r_to_cnt      <= '0;
      end else if (w_state_change) begin
         r_prev_valid  <= 1'b0;
         r_to_cnt      <= '0;
      end else if ((r_state == S_WAIT_TRIG) && w_accept) begin
         r_prev_sample <= adc_data;
         r_prev_valid  <= 1'b1;
         r_to_cnt      <= r_to_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_auto_flag <= 1'b0;
      end else if (w_start_cap) begin
         r_wr_ptr    <= 8'd1;
         r_auto_flag <= ~w_trig;
      end else if (w_cap_write) begin
         r_wr_ptr    <= r_wr_ptr + 8'd1;
      end
   end

   // NOTE: both sample memories take the async reset so a reset blanks the partial frame
   // and the visible frame at once rather than leaving stale samples behind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) r_cap[i] <= '0;
      end else if (w_start_cap) begin
         r_cap[0] <= adc_data;
      end else if (w_cap_write) begin
         r_cap[r_wr_ptr] <= adc_data;
      end
   end

   // The display side only moves on a commit, so a frame is never drawn half-updated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) r_display[i] <= '0;
         r_trig_auto   <= 1'b0;
         r_frame_ready <= 1'b0;
         r_vblnk_d     <= 1'b0;
      end else begin
         r_vblnk_d     <= vblnk;
         r_frame_ready <= w_commit;
         if (w_commit) begin
            for (int i = 0; i < 256; i++) r_display[i] <= r_cap[i];
            r_trig_auto <= r_auto_flag;
         end
      end
   end

   assign data_display = r_display;
   assign frame_ready  = r_frame_ready;
   assign trig_auto    = r_trig_auto;
   assign state        = r_state;

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: directed scenarios plus a randomized soak,
// all compared against a queue-based reference model of the capture rules.
module tb_capture_buffer;

   localparam int AT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] adc_data;
   logic        adc_valid;
   logic [3:0]  decimation;
   logic [11:0] trigger_level;
   logic        trigger_edge;
   logic        hold;
   logic        vblnk;
   logic [11:0] data_display [0:255];
   logic        frame_ready;
   logic        trig_auto;
   logic [1:0]  state;

   always #5 clk = ~clk;

   capture_buffer #(.AUTO_TIMEOUT(AT)) dut (
      .clk           (clk),
      .rst           (rst),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .decimation    (decimation),
      .trigger_level (trigger_level),
      .trigger_edge  (trigger_edge),
      .hold          (hold),
      .vblnk         (vblnk),
      .data_display  (data_display),
      .frame_ready   (frame_ready),
      .trig_auto     (trig_auto),
      .state         (state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fr_dut = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model: state in spec encoding, captured frame kept as a queue.
   int  m_state;
   int  m_skip;
   int  m_prev;
   bit  m_prev_valid;
   int  m_seen;
   int  m_frame[$];
   bit  m_auto;
   int  m_disp [256];
   bit  m_trig_auto;
   bit  m_fr;
   bit  m_vd;

   task automatic model_reset();
      m_state = 0; m_skip = 0; m_prev = 0; m_prev_valid = 0; m_seen = 0;
      m_frame.delete();
      m_auto = 0; m_trig_auto = 0; m_fr = 0; m_vd = 0;
      for (int i = 0; i < 256; i++) m_disp[i] = 0;
   endtask

   task automatic model_step();
      bit acc;
      bit trig;
      int nxt;
      int d;
      int lvl;
      acc  = adc_valid && (m_skip >= int'(decimation));
      d    = int'(adc_data);
      lvl  = int'(trigger_level);
      nxt  = m_state;
      m_fr = 0;
      case (m_state)
         0: if (!hold) nxt = 1;
         1: begin
            if (hold) nxt = 0;
            else if (acc) begin
               if (trigger_edge) trig = m_prev_valid && (m_prev > lvl) && (d <= lvl);
               else              trig = m_prev_valid && (m_prev < lvl) && (d >= lvl);
               if (trig || (m_seen + 1 == AT)) begin
                  m_frame.delete();
                  m_frame.push_back(d);
                  m_auto = !trig;
                  nxt = 2;
               end else begin
                  m_prev = d; m_prev_valid = 1; m_seen++;
               end
            end
         end
         2: if (acc) begin
            m_frame.push_back(d);
            if (m_frame.size() == 256) nxt = 3;
         end
         default: if (vblnk && !m_vd) begin
            for (int i = 0; i < 256; i++) m_disp[i] = m_frame[i];
            m_trig_auto = m_auto;
            m_fr = 1;
            nxt = hold ? 0 : 1;
         end
      endcase
      if (nxt != m_state) m_skip = 0;
      else if (adc_valid) m_skip = acc ? 0 : m_skip + 1;
      if (nxt == 1 && m_state != 1) begin
         m_prev_valid = 0; m_seen = 0;
      end
      m_vd = vblnk;
      m_state = nxt;
   endtask

   task automatic compare_display();
      for (int i = 0; i < 256; i++)
         check($sformatf("disp[%0d]", i), int'(data_display[i]), m_disp[i]);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_step();
      else     model_reset();
      #1;
      check("state", int'(state), m_state);
      check("frame_ready", int'(frame_ready), int'(m_fr));
      check("trig_auto", int'(trig_auto), int'(m_trig_auto));
      if (frame_ready) n_fr_dut++;
      if (frame_ready || m_fr) compare_display();
   endtask

   // Stimulus generator: ramp (per valid sample) or random data.
   int g_val    = 0;
   int g_step   = 0;
   int g_pvalid = 0;
   bit g_random = 0;

   task automatic drive();
      adc_valid = ($urandom_range(99) < g_pvalid);
      if (g_random) adc_data = 12'($urandom);
      else begin
         adc_data = g_val[11:0];
         if (adc_valid) g_val = g_val + g_step;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin cycle(); drive(); end
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int k = 0;
      while (int'(state) != target && k < budget) begin cycle(); drive(); k++; end
      check(tag, int'(state), target);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_state", int'(state), 0);
      check("rst_frame_ready", int'(frame_ready), 0);
      check("rst_trig_auto", int'(trig_auto), 0);
      compare_display();
      run(2);
      #2;
      rst = 1'b1;
   endtask

   task automatic pulse_vblnk(input int high, input int low);
      vblnk = 1'b1; run(high);
      vblnk = 1'b0; run(low);
   endtask

   int base;
   int cnt;

   initial begin
      rst = 1'b0; adc_data = '0; adc_valid = 1'b0; decimation = '0;
      trigger_level = 12'h800; trigger_edge = 1'b0; hold = 1'b0; vblnk = 1'b0;
      model_reset();

      // Rising trigger on an upward ramp.
      do_reset();
      g_pvalid = 0; g_random = 0; drive(); run(2);
      g_val = 'h7F0; g_step = 8; g_pvalid = 100; drive();
      run_until(3, 400, "s1_reach_done");
      base = n_fr_dut;
      vblnk = 1'b1; run(1);
      check("s1_disp0", int'(data_display[0]), 'h800);
      check("s1_disp255", int'(data_display[255]), ('h800 + 255 * 8) % 4096);
      check("s1_trig_auto", int'(trig_auto), 0);
      vblnk = 1'b0; run(4);
      check("s1_one_pulse", n_fr_dut - base, 1);

      // Falling trigger with decimation 3 and sparse valids.
      do_reset();
      decimation = 4'd3; trigger_edge = 1'b1; trigger_level = 12'h400;
      g_pvalid = 0; drive(); run(2);
      g_val = 'h40A; g_step = -1; g_pvalid = 60; drive();
      run_until(3, 4000, "s2_reach_done");
      pulse_vblnk(1, 3);
      check("s2_spacing", int'(data_display[1]), m_disp[0] - 4);
      check("s2_trig_auto", int'(trig_auto), 0);

      // Auto timeout on a flat input.
      do_reset();
      decimation = 4'd0; trigger_edge = 1'b0; trigger_level = 12'h800;
      g_pvalid = 0; g_val = 'h123; g_step = 0; drive(); run(2);
      g_pvalid = 100; drive();
      cnt = 0;
      while (int'(state) == 1 && cnt < 100) begin cycle(); drive(); cnt++; end
      check("s3_auto_start", cnt, AT);
      run_until(3, 600, "s3_reach_done");
      pulse_vblnk(1, 2);
      check("s3_trig_auto", int'(trig_auto), 1);
      for (int i = 0; i < 256; i++)
         check($sformatf("s3_flat[%0d]", i), int'(data_display[i]), 'h123);

      // Hold during capture: one commit, then the display stays frozen.
      do_reset();
      decimation = 4'd1; g_random = 1; g_pvalid = 80;
      trigger_level = 12'($urandom); drive();
      run_until(2, 600, "s4_capture");
      hold = 1'b1;
      run_until(3, 1500, "s4_reach_done");
      base = n_fr_dut;
      pulse_vblnk(2, 3);
      pulse_vblnk(2, 3);
      check("s4_commits", n_fr_dut - base, 1);
      check("s4_idle", int'(state), 0);
      for (int k = 0; k < 5; k++) pulse_vblnk(2, 40);
      check("s4_frozen_commits", n_fr_dut - base, 1);
      compare_display();
      hold = 1'b0;
      run_until(2, 600, "s4_recapture");
      compare_display();
      run_until(3, 1500, "s4_reach_done2");
      pulse_vblnk(1, 2);
      check("s4_second_commit", n_fr_dut - base, 2);

      // Async reset mid-capture, off the clock edge.
      do_reset();
      decimation = 4'd0; g_random = 1; g_pvalid = 100; drive();
      run_until(3, 800, "s5_first_done");
      pulse_vblnk(1, 1);
      run_until(2, 800, "s5_capture");
      cnt = 0;
      while (m_frame.size() < 100 && cnt < 400) begin cycle(); drive(); cnt++; end
      check("s5_mid_capture", int'(state), 2);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      check("s5_async_state", int'(state), 0);
      check("s5_async_fr", int'(frame_ready), 0);
      check("s5_async_trig_auto", int'(trig_auto), 0);
      compare_display();
      #2;
      rst = 1'b1;
      check("s5_post_idle", int'(state), 0);
      run(1);
      check("s5_post_wait", int'(state), 1);
      run(1);
      check("s5_no_instant_capture", int'(state), 1);

      // vblnk already high on entry to DONE must not commit.
      do_reset();
      vblnk = 1'b1; drive();
      run_until(3, 800, "s6_reach_done");
      base = n_fr_dut;
      run(5);
      check("s6_no_commit", n_fr_dut - base, 0);
      vblnk = 1'b0; run(2);
      vblnk = 1'b1; run(2);
      check("s6_commit", n_fr_dut - base, 1);
      vblnk = 1'b0;

      // Randomized soak.
      do_reset();
      for (int c = 0; c < 8000; c++) begin
         if ($urandom_range(99) == 0) decimation = 4'($urandom_range(0, 5));
         if ($urandom_range(199) == 0) hold = ~hold;
         if ($urandom_range(299) == 0) begin
            trigger_level = 12'($urandom);
            trigger_edge  = 1'($urandom);
         end
         if ($urandom_range(499) == 0) begin
            g_random = ~g_random;
            g_step   = ($urandom_range(1) == 1) ? int'($urandom_range(1, 16)) : -int'($urandom_range(1, 16));
         end
         g_pvalid = 75;
         vblnk = ((c % 60) < 3);
         drive();
         cycle();
      end
      compare_display();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/capture_buffer.md
CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 Parameter AUTO_TIMEOUT, default 4096, is the number of accepted samples in WAIT_TRIG without a trigger before an automatic capture starts.
REQ-002 Reset is asynchronous and active-low; all logic is in the single clock domain clk.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 adc_data  in  12  unsigned ADC sample, valid when adc_valid=1.
REQ-006 adc_valid  in  1  one-cycle strobe qualifying adc_data.
REQ-007 decimation  in  4  keep one of every decimation+1 valid samples; 0 = keep all.
REQ-008 trigger_level  in  12  unsigned trigger threshold.
REQ-009 trigger_edge  in  1  0 = rising, 1 = falling.
REQ-010 hold  in  1  1 = freeze display; no new capture is armed.
REQ-011 vblnk  in  1  vertical blanking from the VGA timing chain.
REQ-012 data_display  out  12 x [0:255]  committed frame; this is the draw stage's data_display input.
REQ-013 frame_ready  out  1  one-cycle pulse, high in the cycle after a commit.
REQ-014 trig_auto  out  1  1 = the committed frame was auto-triggered.
REQ-015 state  out  2  FSM state: 00 IDLE, 01 WAIT_TRIG, 10 CAPTURE, 11 DONE.

Function
REQ-016 A sample is accepted when adc_valid=1 and dec_cnt==decimation.
REQ-017 On an accepted sample, dec_cnt clears to 0; on any other adc_valid=1 cycle, dec_cnt increments by 1.
REQ-018 dec_cnt clears on every state transition.
REQ-019 A decimation change takes effect on the next adc_valid; if dec_cnt>decimation, the next adc_valid is accepted.
REQ-020 IDLE: go to WAIT_TRIG on the first cycle after reset release in which hold=0.
REQ-021 WAIT_TRIG: hold=1 returns to IDLE and clears prev_valid and the timeout counter.
REQ-022 WAIT_TRIG: each accepted sample is compared with prev_sample only when prev_valid=1; prev_sample, prev_valid and the timeout counter update afterwards.
REQ-023 Rising trigger condition: prev_sample < trigger_level and sample >= trigger_level.
REQ-024 Falling trigger condition: prev_sample > trigger_level and sample <= trigger_level.
REQ-025 On trigger: the triggering sample is written to cap[0], wr_ptr=1, auto_flag=0, and the FSM goes to CAPTURE.
REQ-026 If no trigger occurs and the timeout counter reaches AUTO_TIMEOUT-1 on an accepted sample, that sample is written to cap[0], wr_ptr=1, auto_flag=1, and the FSM goes to CAPTURE.
REQ-027 A real trigger on that same sample takes priority over the timeout.
REQ-028 CAPTURE: each accepted sample is written to cap[wr_ptr], then wr_ptr increments; wr_ptr is 8-bit.
REQ-029 CAPTURE: the write to cap[255] moves the FSM to DONE; wr_ptr wraps to 0 and is not used further.
REQ-030 CAPTURE ignores hold and trigger inputs.
REQ-031 DONE: vblnk_rise = vblnk & ~vblnk_d, where vblnk_d is vblnk registered once.
REQ-032 DONE: on vblnk_rise, cap[0..255] is copied into data_display in one clock, trig_auto<=auto_flag, and frame_ready=1 in the following cycle.
REQ-033 DONE: after the copy, the FSM goes to WAIT_TRIG if hold=0, otherwise IDLE.
REQ-034 Outside DONE, data_display and trig_auto never change, so the display is never torn mid-frame.
REQ-035 A vblnk already high on entry to DONE does not commit; the next rising edge commits.
REQ-036 Capture-to-display latency is 256 accepted samples plus the wait for the next vblnk rising edge, plus one clock.

Reset
REQ-037 While rst=0: state=IDLE (00), data_display all 0, cap all 0, frame_ready=0, trig_auto=0.
REQ-038 While rst=0, the internal counters, prev_valid and vblnk_d are all cleared to 0.
REQ-039 Reset asserted mid-CAPTURE discards the partial frame and clears data_display immediately, without waiting for a clock edge.

Verification
REQ-040 Rising trigger: decimation=0, level=0x800, ramp 0x7F0, 0x7F8, 0x800, 0x808, ... -> cap[0]=0x800; on vblnk rise, data_display[0]=0x800, data_display[255]=0x800+255*8 mod 4096, frame_ready pulses once, trig_auto=0.
REQ-041 Falling trigger with decimation: decimation=3, falling, level=0x400, descending ramp step 1 per adc_valid -> stored samples are spaced 4 apart; data_display[1]=data_display[0]-4.
REQ-042 Auto timeout: constant input 0x123, AUTO_TIMEOUT=16 -> capture starts on the 16th accepted sample; all 256 entries are 0x123; trig_auto=1.
REQ-043 Hold and tearing: assert hold during CAPTURE, then pulse vblnk twice -> exactly one commit, then state=IDLE; data_display is unchanged by the second vblnk and stays stable until hold=0 and a new frame completes.
REQ-044 Async reset: drop rst mid-CAPTURE at wr_ptr=100, off a clock edge -> outputs clear immediately; after release, the FSM passes IDLE then WAIT_TRIG and needs a fresh trigger.
REQ-045 vblnk high on entry to DONE -> no commit until vblnk falls and rises again.
